// File: rtl/alu_issue_stage.sv
// Issue + EX/WB stage around an external combinational 32-bit ALU.
// Operands are read from a 32x32 register file (R0 reads as zero), latched
// into ALU_A/ALU_B/ALU_OP, and the ALU result is written back one cycle later.
// A RAW dependency on the single in-flight op costs one stall cycle.
module alu_issue_stage #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [4:0]        IN_OP,
  input  logic [ADDR_W-1:0] IN_RS,
  input  logic [ADDR_W-1:0] IN_RT,
  input  logic [ADDR_W-1:0] IN_RD,
  input  logic              IN_USE_IMM,
  input  logic [31:0]       IN_IMM,
  output logic [31:0]       ALU_A,
  output logic [31:0]       ALU_B,
  output logic [4:0]        ALU_OP,
  input  logic [31:0]       ALU_OUT,
  output logic              WB_VALID,
  output logic [ADDR_W-1:0] WB_ADDR,
  output logic [31:0]       WB_DATA,
  output logic [15:0]       WB_CNT,
  input  logic [ADDR_W-1:0] DBG_ADDR,
  output logic [31:0]       DBG_DATA
);

  localparam int NREG = 1 << ADDR_W;

  logic [31:0]       regs [NREG];
  logic              ex_valid;
  logic [ADDR_W-1:0] ex_rd;
  logic [31:0]       rs_val, rt_val;
  logic              ex_wr, hazard, accept;

  // Register file read ports; R0 is forced to zero regardless of storage.
  always_comb begin
    rs_val   = (IN_RS    == '0) ? 32'd0 : regs[IN_RS];
    rt_val   = (IN_RT    == '0) ? 32'd0 : regs[IN_RT];
    DBG_DATA = (DBG_ADDR == '0) ? 32'd0 : regs[DBG_ADDR];
  end

  // Write-back qualifier and RAW hazard against the op sitting in EX.
  // No bypass: after one stall cycle the producer has already been written.
  always_comb begin
    ex_wr    = ex_valid && (ALU_OP != 5'd0) && (ex_rd != '0);
    hazard   = ex_wr && ((IN_RS == ex_rd) || (!IN_USE_IMM && (IN_RT == ex_rd)));
    IN_READY = !rst && !hazard;
    accept   = IN_VALID && IN_READY;
  end

  // Issue: latch operands on accept, otherwise inject a bubble (ALU_OP = 0).
  always_ff @(posedge clk) begin
    if (rst) begin
      ALU_A    <= '0;
      ALU_B    <= '0;
      ALU_OP   <= '0;
      ex_rd    <= '0;
      ex_valid <= 1'b0;
    end else if (accept) begin
      ALU_A    <= rs_val;
      ALU_B    <= IN_USE_IMM ? IN_IMM : rt_val;
      ALU_OP   <= IN_OP;
      ex_rd    <= IN_RD;
      ex_valid <= 1'b1;
    end else begin
      ALU_OP   <= '0;
      ex_valid <= 1'b0;
    end
  end

  // EX/WB: capture ALU result into the register file and the WB port.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      WB_VALID <= 1'b0;
      WB_ADDR  <= '0;
      WB_DATA  <= '0;
      WB_CNT   <= '0;
    end else begin
      WB_VALID <= ex_wr;
      if (ex_wr) begin
        regs[ex_rd] <= ALU_OUT;
        WB_ADDR     <= ex_rd;
        WB_DATA     <= ALU_OUT;
        WB_CNT      <= WB_CNT + 16'd1;
      end
    end
  end

endmodule
